// File: rtl/freq_meter.sv
// freq_meter: frequency counter for bench/loopback checks of clock dividers.
// It counts rising edges of an asynchronous square wave over a gate window
// timed from clk and reports the count (Hz-per-gate units).
//
// Ports:
//   clk          system clock (60 MHz nominal)
//   rst_n        asynchronous active-low reset
//   sig_in       signal under test, asynchronous to clk
//   start        single-cycle pulse, arms one measurement from IDLE
//   cont         1 = re-arm automatically after each result
//   gate_sel     gate window select (GATE0..GATE3 clk cycles)
//   byte_sel     selects one byte of result onto result_byte
//   result       last completed edge count
//   result_byte  combinational byte mux of result
//   valid        one-cycle pulse, coincident with the updated result
//   busy         high while arming or gating
//   overflow     last result saturated
//   no_signal    last result was zero
module freq_meter #(
  parameter int CNT_W = 26,
  parameter int GATE0 = 60000000,
  parameter int GATE1 = 6000000,
  parameter int GATE2 = 600000,
  parameter int GATE3 = 60000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont,
  input  logic [1:0]       gate_sel,
  input  logic [1:0]       byte_sel,
  output logic [CNT_W-1:0] result,
  output logic [7:0]       result_byte,
  output logic             valid,
  output logic             busy,
  output logic             overflow,
  output logic             no_signal
);

  // Timer width covers the longest gate, whichever parameter that is.
  localparam int GATE_MAX_01 = (GATE0 > GATE1) ? GATE0 : GATE1;
  localparam int GATE_MAX_23 = (GATE2 > GATE3) ? GATE2 : GATE3;
  localparam int GATE_MAX    = (GATE_MAX_01 > GATE_MAX_23) ? GATE_MAX_01 : GATE_MAX_23;
  localparam int TW          = (GATE_MAX > 1) ? $clog2(GATE_MAX) : 1;

  typedef enum logic [1:0] {IDLE, ARM, GATE, LATCH} state_t;

  state_t           state_reg, state_next;
  logic             sync_meta_reg, sync_reg, prev_reg;
  logic             edge_pulse;
  logic [TW-1:0]    gate_len_reg, gate_len_next;
  logic [TW-1:0]    timer_reg;
  logic [CNT_W-1:0] count_reg;
  logic             sat_reg;
  logic             gate_last;
  logic [31:0]      result_ext;

  // Two-flop synchronizer followed by one delay flop for rising-edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta_reg <= 1'b0;
      sync_reg      <= 1'b0;
      prev_reg      <= 1'b0;
    end else begin
      sync_meta_reg <= sig_in;
      sync_reg      <= sync_meta_reg;
      prev_reg      <= sync_reg;
    end
  end

  assign edge_pulse = sync_reg & ~prev_reg;

  // Stored as GATEn-1 so the timer compares against its final value directly.
  always_comb begin
    gate_len_next = TW'(GATE0 - 1);
    case (gate_sel)
      2'd0: gate_len_next = TW'(GATE0 - 1);
      2'd1: gate_len_next = TW'(GATE1 - 1);
      2'd2: gate_len_next = TW'(GATE2 - 1);
      2'd3: gate_len_next = TW'(GATE3 - 1);
      default: gate_len_next = TW'(GATE0 - 1);
    endcase
  end

  assign gate_last = (timer_reg == gate_len_reg);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic; start/cont only matter in IDLE and at LATCH.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    case (state_reg)
      IDLE:  if (start || cont) state_next = ARM;
      ARM: begin
        busy       = 1'b1;
        state_next = GATE;
      end
      GATE: begin
        busy = 1'b1;
        if (gate_last) state_next = LATCH;
      end
      LATCH: state_next = cont ? ARM : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Gate timer, edge counter and result registers. valid is registered so
  // that it rises in the same cycle the new result becomes visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_len_reg <= '0;
      timer_reg    <= '0;
      count_reg    <= '0;
      sat_reg      <= 1'b0;
      result       <= '0;
      overflow     <= 1'b0;
      no_signal    <= 1'b0;
      valid        <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state_reg)
        ARM: begin
          gate_len_reg <= gate_len_next;
          timer_reg    <= '0;
          count_reg    <= '0;
          sat_reg      <= 1'b0;
        end
        GATE: begin
          timer_reg <= timer_reg + TW'(1);
          if (edge_pulse) begin
            // Saturate instead of wrapping; an edge at all-ones flags it.
            if (&count_reg) sat_reg   <= 1'b1;
            else            count_reg <= count_reg + CNT_W'(1);
          end
        end
        LATCH: begin
          result    <= count_reg;
          overflow  <= sat_reg;
          no_signal <= (count_reg == '0);
          valid     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Byte mux over a zero-extended copy; byte 3 carries the top bits.
  assign result_ext = 32'(result);

  always_comb begin
    result_byte = result_ext[7:0];
    case (byte_sel)
      2'd0: result_byte = result_ext[7:0];
      2'd1: result_byte = result_ext[15:8];
      2'd2: result_byte = result_ext[23:16];
      2'd3: result_byte = result_ext[31:24];
      default: result_byte = result_ext[7:0];
    endcase
  end

endmodule
